// File: rtl/ode_ram_pkg.sv
// Shared types and helpers for the multi-port ODE RAM.
package ode_ram_pkg;

    // Upper bounds used by the width-generic helpers below.
    localparam int unsigned MAX_WORD_SIZE  = 256;
    localparam int unsigned MAX_NBYTES     = MAX_WORD_SIZE / 8;
    localparam int unsigned MAX_READ_PORTS = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [MAX_WORD_SIZE-1:0] byte_merge(
        input logic [MAX_WORD_SIZE-1:0] old_word,
        input logic [MAX_WORD_SIZE-1:0] new_word,
        input logic [MAX_NBYTES-1:0]    be
    );
        logic [MAX_WORD_SIZE-1:0] merged;
        merged = old_word;
        for (int b = 0; b < int'(MAX_NBYTES); b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Parameter sanity: whole bytes, bounded width, 1..8 ports, latency 0 or 1.
    function automatic bit params_ok(
        input int unsigned word_size,
        input int unsigned read_ports,
        input int unsigned read_latency
    );
        return (word_size % 8 == 0) && (word_size >= 8) && (word_size <= MAX_WORD_SIZE) &&
               (read_ports >= 1) && (read_ports <= MAX_READ_PORTS) && (read_latency <= 1);
    endfunction

endpackage

// File: rtl/ode_ram_clear_ctrl.sv
// Zero-sweep controller: walks every address after reset or a soft clear, then raises ready.
module ode_ram_clear_ctrl
    import ode_ram_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  clr_we,
    output logic [ADDRESS_SIZE:0] clr_addr,
    output logic                  ready
);

    localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] LAST_ADDR = (ADDRESS_SIZE+1)'(DEPTH - 1);

    state_t state;

    // Sweep FSM; clr restarts from address 0 from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_we   <= 1'b1;
            ready    <= 1'b0;
        end else if (clr) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_we   <= 1'b1;
            ready    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= READY;
                        clr_addr <= '0;
                        clr_we   <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + (ADDRESS_SIZE+1)'(1);
                    end
                end
                READY: begin
                    clr_we <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state    <= CLEAR;
                    clr_addr <= '0;
                    clr_we   <= 1'b1;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ode_ram_mp.sv
// Multi-read-port, byte-enable write RAM with a zero sweep and optional registered, write-first reads.
module ode_ram_mp
    import ode_ram_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE = 4,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned READ_PORTS   = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               we,
    input  logic [ADDRESS_SIZE-1:0]            waddr,
    input  logic [WORD_SIZE-1:0]               wdata,
    input  logic [WORD_SIZE/8-1:0]             wbe,
    input  logic [READ_PORTS-1:0]              re,
    input  logic [READ_PORTS*ADDRESS_SIZE-1:0] raddr,
    output logic [READ_PORTS*WORD_SIZE-1:0]    rdata,
    output logic [READ_PORTS-1:0]              rvalid,
    output logic                               ready,
    output logic                               wr_err
);

    localparam int unsigned DEPTH = 1 << ADDRESS_SIZE;

    if (!params_ok(WORD_SIZE, READ_PORTS, READ_LATENCY)) begin : g_bad_params
        $error("ode_ram_mp: unsupported WORD_SIZE/READ_PORTS/READ_LATENCY");
    end

    logic [WORD_SIZE-1:0]  mem [DEPTH];
    logic                  clr_we;
    logic [ADDRESS_SIZE:0] clr_addr;
    logic                  user_wr;
    logic [WORD_SIZE-1:0]  wr_word;

    ode_ram_clear_ctrl #(
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    // A user write lands only when ready and not overridden by a soft clear.
    assign user_wr = ready & we & ~clr;
    assign wr_word = WORD_SIZE'(byte_merge(MAX_WORD_SIZE'(mem[waddr]),
                                           MAX_WORD_SIZE'(wdata),
                                           MAX_NBYTES'(wbe)));

    // Memory write: the sweep owns the array while clearing, otherwise the user port.
    always_ff @(posedge clk) begin
        if (clr_we && !clr_addr[ADDRESS_SIZE]) begin
            mem[clr_addr[ADDRESS_SIZE-1:0]] <= '0;
        end else if (user_wr) begin
            mem[waddr] <= wr_word;
        end
    end

    // Flag every write that arrives while clearing or alongside a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= we & (~ready | clr);
        end
    end

    for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_rd
        logic [ADDRESS_SIZE-1:0] addr;
        assign addr = raddr[p*ADDRESS_SIZE +: ADDRESS_SIZE];

        if (READ_LATENCY == 0) begin : g_comb
            assign rdata[p*WORD_SIZE +: WORD_SIZE] = ready ? mem[addr] : '0;
            assign rvalid[p] = re[p] & ready;
        end else begin : g_reg
            logic [WORD_SIZE-1:0] fwd;
            logic [WORD_SIZE-1:0] data_q;
            logic                 valid_q;

            assign fwd = (user_wr && (waddr == addr)) ? wr_word : mem[addr];

            // Registered read with write-first forwarding; holds data when idle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (!ready) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (re[p]) begin
                    data_q  <= fwd;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end

            assign rdata[p*WORD_SIZE +: WORD_SIZE] = data_q;
            assign rvalid[p] = valid_q;
        end
    end

endmodule

// File: tb/tb_ode_ram_mp.sv
// Directed bench for ode_ram_mp with a cycle-level reference model and literal spot checks.
module tb_ode_ram_mp;

    localparam int unsigned A     = 4;
    localparam int unsigned W     = 32;
    localparam int unsigned RP    = 2;
    localparam int unsigned NB    = W / 8;
    localparam int unsigned DEPTH = 1 << A;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            clr   = 1'b0;
    logic            we    = 1'b0;
    logic [A-1:0]    waddr = '0;
    logic [W-1:0]    wdata = '0;
    logic [NB-1:0]   wbe   = '0;
    logic [RP-1:0]   re    = '0;
    logic [RP*A-1:0] raddr = '0;
    logic [RP*W-1:0] rdata;
    logic [RP-1:0]   rvalid;
    logic            ready;
    logic            wr_err;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ode_ram_mp #(
        .ADDRESS_SIZE (A),
        .WORD_SIZE    (W),
        .READ_PORTS   (RP),
        .READ_LATENCY (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .wbe    (wbe),
        .re     (re),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .ready  (ready),
        .wr_err (wr_err)
    );

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles_left counts remaining sweep cycles; the RAM is usable at zero.
    logic [W-1:0] m_mem [DEPTH];
    int           cycles_left = 0;
    bit           m_valid = 1'b0;
    logic         m_ready, m_err;
    logic [W-1:0] m_rdata [RP];
    logic [RP-1:0] m_rvalid;
    bit           m_rdy, m_wr;
    logic [W-1:0] m_word;
    logic [A-1:0] m_a;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid     = 1'b1;
            cycles_left = DEPTH;
            m_ready     = 1'b0;
            m_err       = 1'b0;
            m_rvalid    = '0;
            for (int p = 0; p < int'(RP); p++) m_rdata[p] = '0;
        end else if (m_valid) begin
            m_rdy  = (cycles_left == 0);
            m_wr   = m_rdy && we && !clr;
            m_word = m_mem[waddr];
            for (int b = 0; b < int'(NB); b++) begin
                if (wbe[b]) m_word[b*8 +: 8] = wdata[b*8 +: 8];
            end
            m_err = we && (!m_rdy || clr);
            for (int p = 0; p < int'(RP); p++) begin
                m_a = raddr[p*A +: A];
                if (!m_rdy) begin
                    m_rdata[p]  = '0;
                    m_rvalid[p] = 1'b0;
                end else if (re[p]) begin
                    m_rdata[p]  = (m_wr && m_a == waddr) ? m_word : m_mem[m_a];
                    m_rvalid[p] = 1'b1;
                end else begin
                    m_rvalid[p] = 1'b0;
                end
            end
            if (clr) begin
                cycles_left = DEPTH;
            end else if (!m_rdy) begin
                m_mem[DEPTH - cycles_left] = '0;
                cycles_left--;
            end else if (m_wr) begin
                m_mem[waddr] = m_word;
            end
            m_ready = (cycles_left == 0);
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("ready",  W'(ready),  W'(m_ready));
            check("wr_err", W'(wr_err), W'(m_err));
            check("rvalid", W'(rvalid), W'(m_rvalid));
            for (int p = 0; p < int'(RP); p++) begin
                check($sformatf("rdata%0d", p), rdata[p*W +: W], m_rdata[p]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_read(input int p, input logic [A-1:0] a);
        re[p] = 1'b1;
        raddr[p*A +: A] = a;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d, input logic [NB-1:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
        we = 1'b0;
    endtask

    // Tick until ready rises, with a bound; returns the number of edges taken.
    task automatic wait_ready(inout int n);
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        check("reset_ready",  W'(ready),  32'h0);
        check("reset_rvalid", W'(rvalid), 32'h0);
        check("reset_wr_err", W'(wr_err), 32'h0);
        check("reset_rdata0", rdata[0 +: W], 32'h0);

        // Sweep length after reset release.
        rst = 1'b0;
        n = 0;
        wait_ready(n);
        check("sweep_len", W'(n), 32'd16);

        set_read(0, 4'd5);
        tick();
        re = '0;
        check("read5_data",  rdata[0 +: W], 32'h0);
        check("read5_valid", W'(rvalid[0]), 32'h1);

        // Byte-enable writes.
        do_write(4'd3, 32'hAABBCCDD, 4'b1111);
        do_write(4'd3, 32'h11223344, 4'b0101);
        set_read(0, 4'd3);
        tick();
        re = '0;
        check("be_merge", rdata[0 +: W], 32'hAA22CC44);

        // Write-first forwarding on port 1; port 0 sees its old word.
        do_write(4'd6, 32'h66666666, 4'b1111);
        we = 1'b1; waddr = 4'd7; wdata = 32'hDEADBEEF; wbe = 4'b1111;
        set_read(1, 4'd7);
        set_read(0, 4'd6);
        tick();
        we = 1'b0; re = '0;
        check("fwd_port1", rdata[W +: W], 32'hDEADBEEF);
        check("fwd_port0", rdata[0 +: W], 32'h66666666);

        // Partial-byte forwarding.
        we = 1'b1; waddr = 4'd3; wdata = 32'h55555555; wbe = 4'b1000;
        set_read(0, 4'd3);
        tick();
        we = 1'b0; re = '0;
        check("fwd_partial", rdata[0 +: W], 32'h5522CC44);

        // Both ports on one address.
        set_read(0, 4'd3);
        set_read(1, 4'd3);
        tick();
        re = '0;
        check("multi_p0", rdata[0 +: W], 32'h5522CC44);
        check("multi_p1", rdata[W +: W], 32'h5522CC44);
        check("multi_rvalid", W'(rvalid), 32'h3);
        tick();
        check("hold_rvalid", W'(rvalid), 32'h0);
        check("hold_data", rdata[0 +: W], 32'h5522CC44);

        // we with no byte enables changes nothing.
        do_write(4'd3, 32'hFFFFFFFF, 4'b0000);
        set_read(0, 4'd3);
        tick();
        re = '0;
        check("wbe_zero", rdata[0 +: W], 32'h5522CC44);

        // Soft clear beats a same-cycle write.
        clr = 1'b1; we = 1'b1; waddr = 4'd4; wdata = 32'hCAFEF00D; wbe = 4'b1111;
        tick();
        clr = 1'b0; we = 1'b0;
        check("clr_wr_err", W'(wr_err), 32'h1);
        check("clr_ready",  W'(ready),  32'h0);
        n = 0;
        wait_ready(n);
        check("clr_sweep_len", W'(n), 32'd16);
        for (int a = 0; a < int'(DEPTH); a++) begin
            set_read(0, A'(a));
            set_read(1, A'(DEPTH - 1 - a));
            tick();
            check("cleared_p0", rdata[0 +: W], 32'h0);
            check("cleared_p1", rdata[W +: W], 32'h0);
        end
        re = '0;

        // Reset mid-sweep restarts it; a write during the sweep is dropped and flagged.
        do_write(4'd0, 32'h0BADF00D, 4'b1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("midsweep_ready", W'(ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        repeat (10) begin tick(); n++; end
        we = 1'b1; waddr = 4'd0; wdata = 32'h12345678; wbe = 4'b1111;
        tick();
        n++;
        we = 1'b0;
        check("clear_wr_err", W'(wr_err), 32'h1);
        wait_ready(n);
        check("restart_sweep_len", W'(n), 32'd16);
        set_read(0, 4'd0);
        tick();
        re = '0;
        check("clear_write_dropped", rdata[0 +: W], 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ode_ram_mp.md
Name: ode_ram_mp

Overview:
- Parametrised multi-read-port, single-write-port word RAM for the ODE accelerator datapath. It holds state vectors and coefficients.
- Successor to the 16x32 scratch RAM. Adds:
  - N read ports
  - byte-enable writes
  - optional registered read with write-first forwarding
  - a sequential clear sweep (async reset, or a synchronous soft clear) with a ready flag
  - a write-while-busy error pulse

Parameters:
- ADDRESS_SIZE, 4, address width; depth DEPTH = 1<<ADDRESS_SIZE.
- WORD_SIZE, 32, data width; must be a multiple of 8; NBYTES = WORD_SIZE/8.
- READ_PORTS, 2, number of independent read ports (1..8).
- READ_LATENCY, 1, 0 = combinational read, 1 = registered read.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous soft clear request; restarts the zero sweep.
- we  in  1  write enable.
- waddr  in  ADDRESS_SIZE  write address.
- wdata  in  WORD_SIZE  write data.
- wbe  in  NBYTES  byte enables; bit b selects wdata[8b+7:8b].
- re  in  READ_PORTS  per-port read enable.
- raddr  in  READ_PORTS*ADDRESS_SIZE  packed read addresses; port p uses bits [p*ADDRESS_SIZE +: ADDRESS_SIZE].
- rdata  out  READ_PORTS*WORD_SIZE  packed read data, same packing.
- rvalid  out  READ_PORTS  per-port read data valid.
- ready  out  1  high when the sweep is done and the RAM accepts traffic.
- wr_err  out  1  one-cycle pulse: a write was attempted while not ready.

Behaviour:
- Reset (rst high, asynchronous):
  - State goes to CLEAR with clr_addr = 0.
  - ready=0, rvalid=0, wr_err=0, registered rdata=0.
  - Memory contents are NOT zeroed by the reset itself; the sweep does that.
- FSM states, CLEAR and READY:
  - CLEAR, each clk: MEM[clr_addr] <= 0 and clr_addr increments. When clr_addr == DEPTH-1 the final zero is written and the next state is READY. The sweep takes exactly DEPTH cycles after rst deasserts.
  - READY: normal operation, ready=1.
  - clr=1 in any state: next state CLEAR, clr_addr=0. This applies even mid-sweep, which restarts the sweep, and takes priority over a write in the same cycle.
- Writes, READY only:
  - On clk with we=1, MEM[waddr] byte b <= wdata byte b for each wbe[b]=1. Other bytes are unchanged.
  - we=1 with wbe=0 is a legal no-op.
- Writes while not ready:
  - we=1 while the state is CLEAR, or in the same cycle clr=1, drops the write.
  - wr_err=1 in the next cycle, for one cycle per offending write.
- Reads, READY only:
  - READ_LATENCY=0:
    - rdata[p] = MEM[raddr[p]] combinationally; rvalid[p] = re[p] & ready.
    - A same-cycle write to the same address is visible only after the edge (old data this cycle).
  - READ_LATENCY=1:
    - At the edge with re[p]=1, rdata[p] is registered and rvalid[p]=1 the next cycle.
    - Write-first: on a same-edge write to raddr[p], rdata[p] carries the merged new word (enabled bytes new, others old).
    - When re[p]=0, rdata[p] holds its last value and rvalid[p]=0.
  - While CLEAR, reads return 0 and rvalid=0.
- Ports:
  - All read ports are independent.
  - Several ports may read the same address in one cycle, and each returns the identical word.
- Addresses: no wrap logic is needed; the full address range is valid.
- Widths: clr_addr is ADDRESS_SIZE+1 bits internally so the terminal compare is not aliased.

Decomposition:
- Package ode_ram_pkg:
  - state enum {CLEAR, READY}
  - function byte_merge(old, new, be) returning WORD_SIZE
  - parameter sanity checks (WORD_SIZE%8==0, READ_PORTS>=1)
- Sub-module ode_ram_clear_ctrl: the sweep FSM.
  - Inputs: clk, rst, clr.
  - Outputs: clr_we, clr_addr, ready.
- The top level muxes the sweep write against the user write and generates the read ports with a generate loop.

Test Plan:
- Reset sweep: pulse rst, DEPTH=16 → ready rises exactly 16 cycles after rst falls; a subsequent read of addr 5 returns 0x00000000 with rvalid=1.
- Byte-enable write: write 0xAABBCCDD to addr 3 with wbe=4'b1111, then 0x11223344 with wbe=4'b0101 → read returns 0xAA22CC44.
- Write-first forwarding (READ_LATENCY=1): same cycle we=1 at addr 7 with 0xDEADBEEF and port 1 re=1 at addr 7 → next cycle rdata[1]=0xDEADBEEF; port 0 reading addr 6 returns its old value.
- Multi-port read: ports 0 and 1 both read addr 3 in one cycle → both rdata slices identical, rvalid=2'b11.
- Soft clear mid-operation: assert clr for one cycle with we=1 → write dropped, wr_err=1 next cycle, ready=0 for 16 cycles, then all addresses read 0.
- Reset mid-sweep and writes during CLEAR:
  - rst asserted at sweep cycle 8 → sweep restarts from addr 0, ready after 16 more cycles.
  - Writes during CLEAR → wr_err pulses, memory unaffected.
